// File: rtl/hack_alu_pkg.sv
// ---------------------------------------------------------------------------
// hack_alu_pkg
// Shared types and constants for the Hack-style ALU datapath.
//   alu_ctrl_t : decoded control word {zx,nx,zy,ny,f,no}, zx in bit 5
//   WORD_W     : datapath width
//   OP_*       : named control words for common Hack ALU functions
// ---------------------------------------------------------------------------
package hack_alu_pkg;

    localparam int WORD_W = 16;

    typedef struct packed {
        logic zx;   // zero x
        logic nx;   // negate x (after zx)
        logic zy;   // zero y
        logic ny;   // negate y (after zy)
        logic f;    // 1: add, 0: bitwise and
        logic no;   // negate result
    } alu_ctrl_t;

    localparam logic [5:0] OP_ZERO   = 6'b101010;
    localparam logic [5:0] OP_ONE    = 6'b111111;
    localparam logic [5:0] OP_ADD    = 6'b000010;
    localparam logic [5:0] OP_SUB_XY = 6'b010011;
    localparam logic [5:0] OP_AND    = 6'b000000;
    localparam logic [5:0] OP_NOT_X  = 6'b001101;
    localparam logic [5:0] OP_NEG1   = 6'b111010;

endpackage

// File: rtl/not16.sv
// ---------------------------------------------------------------------------
// not16
// 16-bit bitwise inverter primitive.
//   a_i : input word
//   y_o : bitwise complement of a_i
// ---------------------------------------------------------------------------
module not16 (
    input  logic [15:0] a_i,
    output logic [15:0] y_o
);

    assign y_o = ~a_i;

endmodule

// File: rtl/alu16_pipe.sv
// ---------------------------------------------------------------------------
// alu16_pipe
// Two-stage pipelined Hack-style 16-bit ALU with valid/ready on both sides.
// Stage 1 conditions the operands (zx/nx, zy/ny) and registers them with
// f/no; stage 2 computes add/and, optional output negate, and registers
// out/zr/ng. Each stage is a valid-qualified register that advances when
// the stage below it is empty or draining.
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset
//   in_valid  : input beat valid
//   in_ready  : stage 1 can accept a beat (combinational from out_ready)
//   x, y      : operands
//   ctrl      : {zx,nx,zy,ny,f,no}
//   out_valid : result beat valid
//   out_ready : consumer accepts result
//   out       : result; zr = (out == 0); ng = out[15]
// ---------------------------------------------------------------------------
module alu16_pipe
    import hack_alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [5:0]  ctrl,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);

    alu_ctrl_t ctrl_s;

    // Stage 1 state
    logic              s1_valid_q, s1_valid_d;
    logic [WORD_W-1:0] x1_q, x1_d;
    logic [WORD_W-1:0] y1_q, y1_d;
    logic              f1_q, f1_d;
    logic              no1_q, no1_d;

    // Stage 2 state
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_q, out_d;
    logic              zr_q, zr_d;
    logic              ng_q, ng_d;

    // Datapath intermediates
    logic [WORD_W-1:0] x_zero_s, x_neg_s, x_cond_s;
    logic [WORD_W-1:0] y_zero_s, y_neg_s, y_cond_s;
    logic [WORD_W-1:0] fn_s, fn_neg_s, res_s;

    // Handshake
    logic s2_adv_s, s1_adv_s, in_ready_s, in_xfer_s;

    assign ctrl_s = alu_ctrl_t'(ctrl);

    // Advance terms: a stage may load when it is empty or the stage below drains.
    // in_ready is forced low during reset so nothing is accepted then.
    assign s2_adv_s   = !out_valid_q || out_ready;
    assign s1_adv_s   = !s1_valid_q || s2_adv_s;
    assign in_ready_s = s1_adv_s && !reset;
    assign in_xfer_s  = in_valid && in_ready_s;

    // Operand zeroing ahead of the negate primitives
    always_comb begin
        x_zero_s = x;
        y_zero_s = y;
        if (ctrl_s.zx) begin
            x_zero_s = 16'h0000;
        end else begin
            x_zero_s = x;
        end
        if (ctrl_s.zy) begin
            y_zero_s = 16'h0000;
        end else begin
            y_zero_s = y;
        end
    end

    not16 u_not_nx (.a_i(x_zero_s), .y_o(x_neg_s));
    not16 u_not_ny (.a_i(y_zero_s), .y_o(y_neg_s));

    assign x_cond_s = ctrl_s.nx ? x_neg_s : x_zero_s;
    assign y_cond_s = ctrl_s.ny ? y_neg_s : y_zero_s;

    // Function stage: add wraps at 16 bits, no carry is kept
    always_comb begin
        fn_s = 16'h0000;
        if (f1_q) begin
            fn_s = x1_q + y1_q;
        end else begin
            fn_s = x1_q & y1_q;
        end
    end

    not16 u_not_no (.a_i(fn_s), .y_o(fn_neg_s));

    assign res_s = no1_q ? fn_neg_s : fn_s;

    // Stage 1 next state: load conditioned operands on advance, else hold
    always_comb begin
        s1_valid_d = s1_valid_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        f1_d       = f1_q;
        no1_d      = no1_q;
        if (s1_adv_s) begin
            s1_valid_d = in_xfer_s;
            x1_d       = x_cond_s;
            y1_d       = y_cond_s;
            f1_d       = ctrl_s.f;
            no1_d      = ctrl_s.no;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2 next state: take stage 1 on advance (bubbles included), else hold
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        zr_d        = zr_q;
        ng_d        = ng_q;
        if (s2_adv_s) begin
            out_valid_d = s1_valid_q;
            out_d       = res_s;
            zr_d        = (res_s == 16'h0000);
            ng_d        = res_s[15];
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Stage 1 registers
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            x1_q       <= 16'h0000;
            y1_q       <= 16'h0000;
            f1_q       <= 1'b0;
            no1_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            f1_q       <= f1_d;
            no1_q      <= no1_d;
        end
    end

    // Stage 2 registers; zr resets high because the reset result is zero
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_q       <= 16'h0000;
            zr_q        <= 1'b1;
            ng_q        <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            zr_q        <= zr_d;
            ng_q        <= ng_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign zr        = zr_q;
    assign ng        = ng_q;

endmodule
